// File: rtl/alu_pkg.sv
// Shared ALU definitions: flag nibble bit positions and multiplier FSM states.
package alu_pkg;

  // Bit positions inside the [N, Z, C, V] flag nibble.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Sequential multiplier control states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_flag_gen.sv
// Flag generator for 2W-bit products; also intended for the divider.
// With i_s low the incoming flags pass through untouched.
module mul_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_product,
  input  logic               i_signed,
  input  logic               i_s,
  input  logic [3:0]         i_flag,
  output logic [3:0]         o_flag
);

  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi;

  assign w_lo = i_product[WIDTH-1:0];
  assign w_hi = i_product[2*WIDTH-1:WIDTH];

  // Z looks at the low word only; C reports unsigned overflow of the low
  // word, V reports that the high word is not a pure sign extension.
  always_comb begin
    o_flag = i_flag;
    if (i_s) begin
      o_flag[FLAG_N] = w_lo[WIDTH-1];
      o_flag[FLAG_Z] = (w_lo == '0);
      o_flag[FLAG_C] = !i_signed && (w_hi != '0);
      o_flag[FLAG_V] = i_signed && (w_hi != {WIDTH{w_lo[WIDTH-1]}});
    end
  end

endmodule

// File: rtl/seq_mul.sv
// Radix-2 shift-add multiplier, WIDTH+2 cycles from start to done.
// Signed operands are reduced to magnitudes up front; the sign is reapplied
// to the full 2W-bit product in FINISH.
module seq_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic             s,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       flag_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       new_flag
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mul_state_t       r_state;
  mul_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic               r_neg;
  logic               r_signed;
  logic               r_s;
  logic [3:0]         r_flag_in;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_product;
  logic [3:0]         w_flag;

  // Magnitude in W unsigned bits; -2^(W-1) maps onto 2^(W-1) naturally.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             en);
    return (en && v[WIDTH-1]) ? -v : v;
  endfunction

  assign w_accept  = (r_state == IDLE) && start;
  assign w_last    = (r_cnt == CNT_W'(1));
  assign w_addend  = r_mplier[0] ? r_mcand : '0;
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_product = r_neg ? -r_acc : r_acc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; busy covers CALC and FINISH.
  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != IDLE);
    case (r_state)
      IDLE:    if (start)  w_state_nxt = CALC;
      CALC:    if (w_last) w_state_nxt = FINISH;
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Iteration counter: loaded with WIDTH on accept, counts down in CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_cnt <= '0;
    else if (w_accept)         r_cnt <= CNT_W'(WIDTH);
    else if (r_state == CALC)  r_cnt <= r_cnt - CNT_W'(1);
  end

  // Operand capture and shift-add datapath; only meaningful while busy.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mcand   <= magnitude(in1, signed_mode);
      r_mplier  <= magnitude(in2, signed_mode);
      r_neg     <= signed_mode && (in1[WIDTH-1] ^ in2[WIDTH-1]);
      r_signed  <= signed_mode;
      r_s       <= s;
      r_flag_in <= flag_in;
      r_acc     <= '0;
    end else if (r_state == CALC) begin
      r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
      r_mplier <= r_mplier >> 1;
    end
  end

  mul_flag_gen #(
    .WIDTH(WIDTH)
  ) u_flag_gen (
    .i_product(w_product),
    .i_signed (r_signed),
    .i_s      (r_s),
    .i_flag   (r_flag_in),
    .o_flag   (w_flag)
  );

  // Output registers: updated in FINISH only, done pulses for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      new_flag  <= '0;
    end else begin
      done <= (r_state == FINISH);
      if (r_state == FINISH) begin
        result    <= w_product[WIDTH-1:0];
        result_hi <= w_product[2*WIDTH-1:WIDTH];
        new_flag  <= w_flag;
      end
    end
  end

endmodule

// File: tb/tb_seq_mul.sv
// Bench for seq_mul: WIDTH=32 and WIDTH=8 instances, queue scoreboard.
module tb_seq_mul;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [3:0]  fl;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start32, sm32, s32;
  logic [31:0] a32, b32;
  logic [3:0]  f32;
  logic        busy32, done32;
  logic [31:0] res32, hi32;
  logic [3:0]  nf32;

  logic        start8, sm8, s8;
  logic [7:0]  a8, b8;
  logic [3:0]  f8;
  logic        busy8, done8;
  logic [7:0]  res8, hi8;
  logic [3:0]  nf8;

  exp_t q32[$];
  exp_t q8[$];
  int   n_cmp = 0;
  int   n_err = 0;

  seq_mul #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .signed_mode(sm32), .s(s32),
    .in1(a32), .in2(b32), .flag_in(f32), .busy(busy32), .done(done32),
    .result(res32), .result_hi(hi32), .new_flag(nf32)
  );

  seq_mul #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8), .s(s8),
    .in1(a8), .in2(b8), .flag_in(f8), .busy(busy8), .done(done8),
    .result(res8), .result_hi(hi8), .new_flag(nf8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic sm, input logic sv,
                       input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
    if (w == 32) begin
      start32 = st; sm32 = sm; s32 = sv; a32 = a; b32 = b; f32 = f;
    end else begin
      start8 = st; sm8 = sm; s8 = sv; a8 = a[7:0]; b8 = b[7:0]; f8 = f;
    end
  endtask

  task automatic sample(input int w, output logic dn, output logic bs,
                        output logic [31:0] lo, output logic [31:0] hi, output logic [3:0] fl);
    if (w == 32) begin
      dn = done32; bs = busy32; lo = res32; hi = hi32; fl = nf32;
    end else begin
      dn = done8; bs = busy8; lo = {24'd0, res8}; hi = {24'd0, hi8}; fl = nf8;
    end
  endtask

  // Independent reference: native multiply on sign/zero-extended operands.
  function automatic exp_t model(input int w, input logic sm, input logic sv,
                                 input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
    exp_t        r;
    logic [63:0] mask, p, lo, hi;
    longint      pa, pb;
    mask = (64'd1 << w) - 64'd1;
    pa = longint'({32'd0, a} & mask);
    pb = longint'({32'd0, b} & mask);
    if (sm && a[w-1]) pa = pa - (longint'(1) << w);
    if (sm && b[w-1]) pb = pb - (longint'(1) << w);
    p  = 64'(pa * pb);
    lo = p & mask;
    hi = (p >> w) & mask;
    r.lo = lo[31:0];
    r.hi = hi[31:0];
    if (sv) begin
      r.fl[3] = lo[w-1];
      r.fl[2] = (lo == 64'd0);
      r.fl[1] = !sm && (hi != 64'd0);
      r.fl[0] = sm && (hi != (lo[w-1] ? mask : 64'd0));
    end else begin
      r.fl = f;
    end
    return r;
  endfunction

  // Raise start for one edge; t0 is the cycle count just after acceptance.
  task automatic launch(input int w, input logic sm, input logic sv,
                        input logic [31:0] a, input logic [31:0] b, input logic [3:0] f,
                        input exp_t e, input bit push, output int t0);
    logic dn, bs;
    logic [31:0] lo, hi;
    logic [3:0]  fl;
    @(negedge clk);
    drive(w, 1'b1, sm, sv, a, b, f);
    if (push) begin
      if (w == 32) q32.push_back(e);
      else         q8.push_back(e);
    end
    @(posedge clk);
    #1;
    t0 = cyc;
    drive(w, 1'b0, ~sm, ~sv, $urandom, $urandom, ~f);
    sample(w, dn, bs, lo, hi, fl);
    check($sformatf("w%0d_busy_after_start", w), 64'(bs), 64'd1);
  endtask

  // Bounded wait for done, then pop the scoreboard and compare.
  task automatic wait_done(input int w, input int t0, input string tag, output exp_t e);
    logic dn, bs;
    logic [31:0] lo, hi;
    logic [3:0]  fl;
    bit seen;
    seen = 1'b0;
    dn = 1'b0; bs = 1'b0; lo = '0; hi = '0; fl = '0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      sample(w, dn, bs, lo, hi, fl);
      seen = dn;
    end
    check({tag, "_latency"}, 64'(cyc - t0 + 1), 64'(w + 2));
    check({tag, "_busy_in_done"}, 64'(bs), 64'd0);
    e = '{32'd0, 32'd0, 4'd0};
    if (w == 32 && q32.size() > 0)     e = q32.pop_front();
    else if (w == 8 && q8.size() > 0)  e = q8.pop_front();
    else begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_scoreboard observed=done expected=no_pending_entry", tag);
    end
    check({tag, "_result"},    64'(lo), 64'(e.lo));
    check({tag, "_result_hi"}, 64'(hi), 64'(e.hi));
    check({tag, "_flags"},     64'(fl), 64'(e.fl));
  endtask

  // One cycle later: done has dropped and outputs still hold.
  task automatic hold_check(input int w, input string tag, input exp_t e);
    logic dn, bs;
    logic [31:0] lo, hi;
    logic [3:0]  fl;
    @(posedge clk);
    #1;
    sample(w, dn, bs, lo, hi, fl);
    check({tag, "_done_pulse"}, 64'(dn), 64'd0);
    check({tag, "_hold_result"}, 64'(lo), 64'(e.lo));
    check({tag, "_hold_flags"},  64'(fl), 64'(e.fl));
  endtask

  initial begin
    exp_t        e, got;
    int          t0, t_first, nd;
    logic        dn, bs;
    logic [31:0] lo, hi, ra, rb;
    logic [3:0]  fl, rf;

    drive(32, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(8,  1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    sample(32, dn, bs, lo, hi, fl);
    check("rst32_busy", 64'(bs), 64'd0);
    check("rst32_done", 64'(dn), 64'd0);
    check("rst32_result", 64'(lo), 64'd0);
    check("rst32_result_hi", 64'(hi), 64'd0);
    check("rst32_flags", 64'(fl), 64'd0);
    sample(8, dn, bs, lo, hi, fl);
    check("rst8_busy", 64'(bs), 64'd0);
    check("rst8_done", 64'(dn), 64'd0);
    check("rst8_result", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=32 directed cases.
    e = '{32'd6, 32'd0, 4'b0000};
    launch(32, 1'b1, 1'b1, 32'd2, 32'd3, 4'b0000, e, 1'b1, t0);
    wait_done(32, t0, "s_2x3", got);
    hold_check(32, "s_2x3", got);

    e = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'b1000};
    launch(32, 1'b1, 1'b1, 32'd1, 32'hFFFF_FFFD, 4'b0000, e, 1'b1, t0);
    wait_done(32, t0, "s_1xm3", got);

    e = '{32'hFFFF_FFF7, 32'h0000_0008, 4'b1010};
    launch(32, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd9, 4'b0000, e, 1'b1, t0);
    wait_done(32, t0, "u_max_x9", got);

    e = '{32'd12, 32'd0, 4'b1010};
    launch(32, 1'b1, 1'b0, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 4'b1010, e, 1'b1, t0);
    wait_done(32, t0, "s0_m6xm2", got);

    e = '{32'd0, 32'd0, 4'b0100};
    launch(32, 1'b1, 1'b1, 32'd0, 32'd0, 4'b1010, e, 1'b1, t0);
    wait_done(32, t0, "s_0x0", got);

    e = model(32, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 4'b0000);
    launch(32, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 4'b0000, e, 1'b1, t0);
    wait_done(32, t0, "s_min_x_min", got);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      rf = 4'($urandom);
      e = model(32, 1'(i), 1'(i != 3), ra, rb, rf);
      launch(32, 1'(i), 1'(i != 3), ra, rb, rf, e, 1'b1, t0);
      wait_done(32, t0, $sformatf("rand%0d", i), got);
    end

    // WIDTH=8: most negative operand, mid-op start ignored, back-to-back.
    e = '{32'h80, 32'h00, 4'b1001};
    launch(8, 1'b1, 1'b1, 32'h80, 32'hFF, 4'b0000, e, 1'b1, t0);
    repeat (3) @(negedge clk);
    drive(8, 1'b1, 1'b0, 1'b1, 32'd3, 32'd3, 4'b1111);
    @(negedge clk);
    drive(8, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 4'b0000);
    wait_done(8, t0, "w8_min_x_m1", got);
    t_first = cyc;
    e = '{32'h01, 32'hFE, 4'b0010};
    launch(8, 1'b0, 1'b1, 32'hFF, 32'hFF, 4'b0000, e, 1'b1, t0);
    wait_done(8, t0, "w8_b2b", got);
    check("w8_done_to_done", 64'(cyc - t_first), 64'd10);

    // Abort in CALC cycle 5: asynchronous clear, no done afterwards.
    launch(32, 1'b0, 1'b1, 32'd5, 32'd7, 4'b0000, e, 1'b0, t0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    sample(32, dn, bs, lo, hi, fl);
    check("abort_busy", 64'(bs), 64'd0);
    check("abort_done", 64'(dn), 64'd0);
    check("abort_result", 64'(lo), 64'd0);
    check("abort_result_hi", 64'(hi), 64'd0);
    check("abort_flags", 64'(fl), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done32 === 1'b1) nd++;
    end
    check("abort_no_done", 64'(nd), 64'd0);

    e = '{32'd35, 32'd0, 4'b0000};
    launch(32, 1'b0, 1'b1, 32'd5, 32'd7, 4'b0000, e, 1'b1, t0);
    wait_done(32, t0, "after_abort", got);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_mul.md
# seq_mul

Parametrised multi-cycle multiplier for the ALU, the successor to the single-cycle combinational MUL. Computes a full 2×WIDTH-bit product using a radix-2 shift-add datapath. Supports signed and unsigned modes and a start/busy/done handshake, and produces the ALU's [N, Z, C, V] flag nibble under the same conditional flag-update (S) rule as the other ALU units. Sits beside ADD/MUL in the ALU; the ALU's control logic stalls on `busy`.

## Interface
- `WIDTH`, 32: operand width in bits; ≥ 4.
- `clk` in 1: clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only while idle.
- `signed_mode` in 1: 1 = two's-complement operands, 0 = unsigned; sampled with `start`.
- `s` in 1: flag-update enable; sampled with `start`.
- `in1` in WIDTH: multiplicand; sampled with `start`.
- `in2` in WIDTH: multiplier; sampled with `start`.
- `flag_in` in 4: current [N, Z, C, V]; sampled with `start`.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse; result and flags are valid.
- `result` out WIDTH: low product word.
- `result_hi` out WIDTH: high product word.
- `new_flag` out 4: [N, Z, C, V].

## Operation
- FSM states are IDLE, CALC and FINISH.
- IDLE → CALC on `start`:
  - Latch `signed_mode`, `s` and `flag_in`.
  - Latch operand magnitudes: |in1| and |in2| in signed mode, raw values otherwise.
  - Latch the result sign, `neg = in1[W-1] ^ in2[W-1]`, in signed mode; 0 otherwise.
  - Clear the 2W accumulator and load the counter with WIDTH.
- CALC, once per cycle:
  - If the multiplier LSB is 1, add the multiplicand into the upper accumulator half, with carry into a W+1-bit sum.
  - Shift the accumulator right by 1 and decrement the counter.
  - After WIDTH iterations, go to FINISH.
- FINISH:
  - product = neg ? −acc : acc, computed in 2W bits.
  - Register `result`/`result_hi` and `new_flag`, pulse `done`, return to IDLE.
- Magnitude of −2^(W−1) is 2^(W−1), held in W unsigned bits; no special case is needed.
- Flags when `s`=1:
  - N = result[W−1].
  - Z = (result == 0), low word only.
  - C = unsigned mode ? (result_hi != 0) : 0.
  - V = signed mode ? (result_hi != {W{result[W−1]}}) : 0.
- Flags when `s`=0: `new_flag` = latched `flag_in`, unchanged.
- `result`, `result_hi` and `new_flag` hold their value until the next FINISH.

## Timing
- Reset values:
  - `busy`=0, `done`=0.
  - `result`=0, `result_hi`=0, `new_flag`=0000.
  - FSM in IDLE, counter=0.
- Start accepted at edge 0 → `busy`=1 from edge 0 to edge WIDTH+1.
- `done`=1 and outputs valid in the cycle after edge WIDTH+1, i.e. latency WIDTH+2 cycles (34 for WIDTH=32).
- `busy`=0 in the `done` cycle. A `start` in that cycle is accepted (back-to-back), with no dead cycle.
- `start` while `busy`=1 is ignored; operands and mode are not re-sampled.
- `rst_n` low mid-operation aborts immediately: all outputs return to their reset values and no `done` is issued.
- `done` is never asserted without a preceding accepted `start`.

## Structure
- Package `alu_pkg`:
  - Flag bit indices: `FLAG_N`=3, `FLAG_Z`=2, `FLAG_C`=1, `FLAG_V`=0.
  - FSM state enum `mul_state_t`.
- Sub-module `mul_flag_gen`: combinational; takes the 2W product, mode, `s` and `flag_in`, and produces `new_flag`. It is shared later with a divider.
- Counter width is $clog2(WIDTH+1).

## Test plan
- WIDTH=32, signed, s=1, in1=2, in2=3, flag_in=0000 → `done` 34 cycles after start; result=6, hi=0, flags 0000.
- Signed, s=1, in1=1, in2=−3 → result=0xFFFFFFFD, hi=0xFFFFFFFF, flags 1000.
- Unsigned, s=1, in1=0xFFFFFFFF, in2=9 → result=0xFFFFFFF7, hi=0x00000008, flags 1010.
- Signed, s=0, in1=−6, in2=−2, flag_in=1010 → result=12, hi=0, flags 1010 (unchanged). Then, with s=1, in1=0, in2=0 → flags 0100.
- WIDTH=8, signed, in1=−128, in2=−1 → result=0x80, hi=0x00, flags 1001. Second start pulsed mid-op is ignored; back-to-back start on the `done` cycle gives a second `done` exactly 10 cycles later.
- Deassert `rst_n` at CALC cycle 5 → outputs zero, `busy`=0 asynchronously, and no `done` follows; a fresh start afterwards completes normally.
